// File: rtl/spike_event_scanner.sv
// Sweeps the 4-bank spike memory one packed word at a time and emits one
// (neuron index, spike value) event per non-zero lane on a valid/ready stream.
module spike_event_scanner #(
    parameter int RAM_WIDTH    = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     num_neurons,
    output logic                    mem_en,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [4*RAM_WIDTH-1:0]  mem_dout16,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [ADDR_WIDTH-1:0]   ev_idx,
    output logic [RAM_WIDTH-1:0]    ev_val,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     ev_count
);

    localparam int WORD_W = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SCAN,
        DONE
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH:0]    n_reg;
    logic [WORD_W-1:0]      word_ptr;
    logic [1:0]             lane;
    logic [3:0]             wait_cnt;
    logic [4*RAM_WIDTH-1:0] data_reg;
    logic                   accepted;
    logic [ADDR_WIDTH:0]    count_reg;

    logic [ADDR_WIDTH-1:0]  cur_idx;
    logic [RAM_WIDTH-1:0]   nibble;
    logic                   out_of_range;
    logic                   lane_live;
    logic                   ev_valid_int;
    logic                   step;
    logic                   end_of_word;
    logic [WORD_W:0]        next_word;
    logic                   more_words;
    logic                   wait_last;

    assign cur_idx      = {word_ptr, lane};
    assign out_of_range = ({1'b0, cur_idx} >= n_reg);
    assign lane_live    = !out_of_range && (nibble != '0);
    assign ev_valid_int = (state == SCAN) && lane_live && !accepted;
    // A lane finishes either by being skipped or on the cycle after its handshake,
    // which also gives the required gap in ev_valid between accepted events.
    assign step         = accepted || !lane_live;
    assign end_of_word  = (lane == 2'd3) || out_of_range;
    assign next_word    = {1'b0, word_ptr} + 1'b1;
    assign more_words   = ({next_word, 2'b00} < n_reg);
    assign wait_last    = (wait_cnt == 4'(READ_LATENCY));

    always_comb begin
        nibble = '0;
        case (lane)
            2'd0:    nibble = data_reg[4*RAM_WIDTH-1 -: RAM_WIDTH];
            2'd1:    nibble = data_reg[3*RAM_WIDTH-1 -: RAM_WIDTH];
            2'd2:    nibble = data_reg[2*RAM_WIDTH-1 -: RAM_WIDTH];
            default: nibble = data_reg[RAM_WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (num_neurons == '0) ? DONE : READ;
                end
            end
            READ: next_state = WAIT;
            WAIT: begin
                if (wait_last) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (step && end_of_word) begin
                    next_state = more_words ? READ : DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg     <= '0;
            word_ptr  <= '0;
            lane      <= '0;
            wait_cnt  <= '0;
            data_reg  <= '0;
            accepted  <= 1'b0;
            count_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg     <= num_neurons;
                        count_reg <= '0;
                        word_ptr  <= '0;
                        lane      <= '0;
                        accepted  <= 1'b0;
                    end
                end
                READ: wait_cnt <= 4'd1;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_last) begin
                        data_reg <= mem_dout16;
                        lane     <= '0;
                        accepted <= 1'b0;
                    end
                end
                SCAN: begin
                    if (ev_valid_int && ev_ready) begin
                        count_reg <= count_reg + 1'b1;
                        accepted  <= 1'b1;
                    end else if (step) begin
                        accepted <= 1'b0;
                        if (end_of_word) begin
                            if (more_words) begin
                                word_ptr <= word_ptr + 1'b1;
                            end
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The address is held through WAIT so a memory that re-samples it still sees the same word.
    always_comb begin
        mem_en      = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = 1'b0;
        done        = 1'b0;
        ev_valid    = ev_valid_int;
        ev_idx      = ev_valid_int ? cur_idx : '0;
        ev_val      = ev_valid_int ? nibble : '0;
        ev_count    = count_reg;
        case (state)
            READ: begin
                mem_en      = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = {word_ptr, 2'b00};
                busy        = 1'b1;
            end
            WAIT: begin
                mem_en      = 1'b1;
                mem_rd_addr = {word_ptr, 2'b00};
                busy        = 1'b1;
            end
            SCAN:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spike_event_scanner.sv
// Runs a latency-1 and a latency-2 scanner side by side on the same memory image and
// compares both event streams against a per-neuron reference of the sweep.
module tb_spike_event_scanner;

    localparam int W  = 4;
    localparam int AW = 10;
    localparam int NW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [AW:0]   num_neurons;
    logic          ev_ready;

    logic          mem_en      [2];
    logic          mem_rd_en   [2];
    logic [AW-1:0] mem_rd_addr [2];
    logic [15:0]   mem_dout16  [2];
    logic          ev_valid    [2];
    logic [AW-1:0] ev_idx      [2];
    logic [W-1:0]  ev_val      [2];
    logic          busy        [2];
    logic          done        [2];
    logic [AW:0]   ev_count    [2];

    spike_event_scanner #(.RAM_WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
        .mem_en(mem_en[0]), .mem_rd_en(mem_rd_en[0]), .mem_rd_addr(mem_rd_addr[0]),
        .mem_dout16(mem_dout16[0]), .ev_valid(ev_valid[0]), .ev_ready(ev_ready),
        .ev_idx(ev_idx[0]), .ev_val(ev_val[0]), .busy(busy[0]), .done(done[0]),
        .ev_count(ev_count[0])
    );

    spike_event_scanner #(.RAM_WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
        .mem_en(mem_en[1]), .mem_rd_en(mem_rd_en[1]), .mem_rd_addr(mem_rd_addr[1]),
        .mem_dout16(mem_dout16[1]), .ev_valid(ev_valid[1]), .ev_ready(ev_ready),
        .ev_idx(ev_idx[1]), .ev_val(ev_val[1]), .busy(busy[1]), .done(done[1]),
        .ev_count(ev_count[1])
    );

    // Memory model: read data is valid for exactly one cycle, junk otherwise.
    logic [15:0] mem [NW];
    logic [15:0] pd  [2][2];
    logic        pv  [2][2];
    logic [15:0] junk;

    always @(posedge clk) begin
        junk <= 16'($urandom);
        for (int k = 0; k < 2; k++) begin
            pv[k][0] <= mem_rd_en[k];
            pd[k][0] <= mem[mem_rd_addr[k][AW-1:2]];
            pv[k][1] <= pv[k][0];
            pd[k][1] <= pd[k][0];
        end
    end

    always_comb begin
        mem_dout16[0] = pv[0][0] ? pd[0][0] : junk;
        mem_dout16[1] = pv[1][1] ? pd[1][1] : junk;
    end

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    int ready_mode = 0;
    initial begin
        ev_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ev_ready = 1'b1;
                1:       ev_ready = 1'($urandom_range(0, 1));
                default: ev_ready = 1'b0;
            endcase
        end
    end

    // Monitor: collects accepted events, read addresses and done pulses; checks hold-under-stall.
    int            evq [2][$];
    int            rdq [2][$];
    int            done_cnt [2];
    logic          prev_stall [2];
    logic [AW-1:0] prev_idx [2];
    logic [W-1:0]  prev_val [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            done_cnt[k]   = 0;
            prev_stall[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    prev_stall[k] = 1'b0;
                end else begin
                    if (prev_stall[k]) begin
                        checkOutput("stall_valid", ev_valid[k], 1);
                        checkOutput("stall_idx", ev_idx[k], prev_idx[k]);
                        checkOutput("stall_val", ev_val[k], prev_val[k]);
                    end
                    if (ev_valid[k]) begin
                        checkOutput("val_nonzero", ev_val[k] != '0, 1);
                        if (ev_ready) evq[k].push_back(int'({ev_idx[k], ev_val[k]}));
                    end
                    prev_stall[k] = ev_valid[k] && !ev_ready;
                    prev_idx[k]   = ev_idx[k];
                    prev_val[k]   = ev_val[k];
                    if (mem_rd_en[k]) rdq[k].push_back(int'(mem_rd_addr[k]));
                    if (done[k]) begin
                        done_cnt[k]++;
                        checkOutput("done_busy", busy[k], 0);
                    end
                end
            end
        end
    end

    task automatic checkIdle(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput({tag, "_ctrl"}, {mem_en[k], mem_rd_en[k], ev_valid[k], busy[k], done[k]}, 0);
            checkOutput({tag, "_addr"}, mem_rd_addr[k], 0);
            checkOutput({tag, "_ev"}, {ev_idx[k], ev_val[k]}, 0);
            checkOutput({tag, "_cnt"}, ev_count[k], 0);
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int k = 0; k < 2; k++) begin
            evq[k].delete();
            rdq[k].delete();
            done_cnt[k] = 0;
        end
        @(posedge clk);
        #1;
        num_neurons = (AW+1)'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (n == 0) checkOutput("n0_done_next", done[k], 1);
            else        checkOutput("busy_rise", busy[k], 1);
        end
    endtask

    task automatic checkSweep(input int n);
        int exp_q[$];
        int cyc;
        logic [15:0] w;
        int nib;
        cyc = 0;
        while ((done_cnt[0] == 0 || done_cnt[1] == 0) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("sweep_timeout", cyc < 20000, 1);
        repeat (4) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            w   = mem[i / 4];
            nib = int'((w >> (4 * (3 - (i % 4)))) & 16'hF);
            if (nib != 0) exp_q.push_back(i * 16 + nib);
        end
        for (int k = 0; k < 2; k++) begin
            checkOutput("ev_num", evq[k].size(), exp_q.size());
            for (int j = 0; j < evq[k].size() && j < exp_q.size(); j++)
                checkOutput("ev_idx_val", evq[k][j], exp_q[j]);
            checkOutput("ev_count", ev_count[k], exp_q.size());
            checkOutput("done_pulses", done_cnt[k], 1);
            checkOutput("read_num", rdq[k].size(), (n + 3) / 4);
            for (int j = 0; j < rdq[k].size() && j < (n + 3) / 4; j++)
                checkOutput("read_addr", rdq[k][j], j * 4);
            checkOutput("idle_busy", busy[k], 0);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < NW; i++) mem[i] = 16'h0;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NW; i++)
            for (int b = 0; b < 4; b++)
                mem[i][b*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        num_neurons = '0;
        clearMem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        // Directed sweeps
        applyStimulus(8);
        checkSweep(8);
        mem[0] = 16'h1203;
        mem[1] = 16'h000F;
        applyStimulus(8);
        checkSweep(8);
        mem[0] = 16'h0000;
        mem[1] = 16'hFFFF;
        applyStimulus(6);
        checkSweep(6);
        applyStimulus(0);
        checkSweep(0);

        // Hold the first event off for 10 cycles
        mem[0] = 16'h1203;
        mem[1] = 16'h000F;
        ready_mode = 2;
        applyStimulus(8);
        cyc = 0;
        while (!(ev_valid[0] && ev_valid[1]) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("bp_valid_seen", cyc < 50, 1);
        repeat (10) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("bp_hold_count", ev_count[k], 0);
            checkOutput("bp_hold_idx", ev_idx[k], 0);
            checkOutput("bp_hold_val", ev_val[k], 1);
        end
        ready_mode = 0;
        checkSweep(8);

        // Random images, random sizes, random backpressure
        ready_mode = 1;
        for (int t = 0; t < 24; t++) begin
            fillRandom();
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1024)) : int'($urandom_range(0, 40));
            applyStimulus(n);
            checkSweep(n);
        end
        fillRandom();
        applyStimulus(1024);
        checkSweep(1024);

        // Reset in the middle of a sweep
        fillRandom();
        applyStimulus(400);
        repeat (60) @(negedge clk);
        for (int k = 0; k < 2; k++) checkOutput("busy_before_rst", busy[k], 1);
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            @(negedge clk);
            checkIdle("mid_rst");
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) done_cnt[k] = 0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("no_done_after_rst", done_cnt[k], 0);
            checkOutput("idle_after_rst", busy[k], 0);
        end
        ready_mode = 0;
        applyStimulus(13);
        checkSweep(13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
